// File: rtl/rv_pkg.sv
// Shared definitions for the RISC-V fetch front end: PC-generator states,
// instruction alignment mask and the default trap vector.
package rv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_e;

  localparam logic [1:0]  INSTR_ALIGN_MASK = 2'b11;
  localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0100;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect buffer. Holds the latest control-flow event seen
// while a fetch is stalled; a pending trap can only be replaced by another trap.
module pc_redirect_buf #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic             wr_is_trap,
  input  logic [width-1:0] wr_target,
  input  logic             clr,
  output logic             valid,
  output logic [width-1:0] target
);

  logic             valid_q, valid_d;
  logic             is_trap_q, is_trap_d;
  logic [width-1:0] target_q, target_d;
  logic             accept_s;

  // Overwrite priority: empty slot or pending redirect always yields; pending trap yields only to a trap.
  always_comb begin
    accept_s  = wr_en & (~valid_q | ~is_trap_q | wr_is_trap);
    valid_d   = valid_q;
    is_trap_d = is_trap_q;
    target_d  = target_q;
    if (clr) begin
      valid_d   = 1'b0;
      is_trap_d = 1'b0;
    end else if (accept_s) begin
      valid_d   = 1'b1;
      is_trap_d = wr_is_trap;
      target_d  = wr_target;
    end else begin
      valid_d   = valid_q;
      is_trap_d = is_trap_q;
      target_d  = target_q;
    end
  end

  // Pending entry storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      is_trap_q <= 1'b0;
      target_q  <= {width{1'b0}};
    end else begin
      valid_q   <= valid_d;
      is_trap_q <= is_trap_d;
      target_q  <= target_d;
    end
  end

  assign valid  = valid_q;
  assign target = target_q;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: IDLE/RUN/HALTED control, valid/ready fetch
// handshake, trap and redirect sources with a pending buffer across stalls.
module pc_gen
  import rv_pkg::*;
#(
  parameter int               width     = 32,
  parameter logic [width-1:0] RESET_VEC = {width{1'b0}},
  parameter logic [width-1:0] TRAP_VEC  = TRAP_VEC_DEFAULT,
  parameter logic [width-1:0] INC       = {{(width-3){1'b0}}, 3'd4}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             halt,
  input  logic             redirect_valid,
  input  logic [width-1:0] redirect_target,
  input  logic             trap,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [width-1:0] PC,
  output logic             misalign,
  output logic [width-1:0] badaddr
);

  state_e           state_q, state_d;
  logic [width-1:0] pc_q, pc_d;
  logic [width-1:0] badaddr_q, badaddr_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             misalign_q, misalign_d;

  logic             outstanding_s, handshake_s;
  logic             redir_mis_s, ev_valid_s, ev_is_trap_s;
  logic [width-1:0] ev_target_s;
  logic             pend_valid_s, pend_clr_s, pend_wr_s;
  logic [width-1:0] pend_target_s;

  // Classify this cycle's event; a misaligned redirect is folded into a trap.
  always_comb begin
    outstanding_s = fetch_valid_q & ~fetch_ready;
    handshake_s   = fetch_valid_q & fetch_ready;
    redir_mis_s   = redirect_valid & ((redirect_target[1:0] & INSTR_ALIGN_MASK) != 2'b00);
    ev_valid_s    = trap | redirect_valid;
    ev_is_trap_s  = trap | redir_mis_s;
    ev_target_s   = ev_is_trap_s ? TRAP_VEC : redirect_target;
    pend_wr_s     = outstanding_s & ev_valid_s;
  end

  pc_redirect_buf #(.width(width)) u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (pend_wr_s),
    .wr_is_trap (ev_is_trap_s),
    .wr_target  (ev_target_s),
    .clr        (pend_clr_s),
    .valid      (pend_valid_s),
    .target     (pend_target_s)
  );

  // FSM next state and next-PC selection.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_clr_s = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = RUN;
        if (ev_valid_s) pc_d = ev_target_s;
        else            pc_d = pc_q;
      end
      RUN: begin
        if (handshake_s) begin
          pend_clr_s = pend_valid_s;
          if (pend_valid_s)    pc_d = pend_target_s;
          else if (ev_valid_s) pc_d = ev_target_s;
          else                 pc_d = pc_q + INC;
          if (halt) state_d = HALTED;
          else      state_d = RUN;
        end else begin
          // Stalled: the request stays on the bus unchanged.
          pc_d    = pc_q;
          state_d = RUN;
        end
      end
      HALTED: begin
        if (ev_valid_s) pc_d = ev_target_s;
        else            pc_d = pc_q;
        if (halt) state_d = HALTED;
        else      state_d = RUN;
      end
      default: begin
        state_d = IDLE;
        pc_d    = RESET_VEC;
      end
    endcase
  end

  // Output-side next values: request valid, misalign pulse, captured bad address.
  always_comb begin
    fetch_valid_d = (state_d == RUN);
    misalign_d    = redir_mis_s;
    if (redir_mis_s) badaddr_d = redirect_target;
    else             badaddr_d = badaddr_q;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_VEC;
      fetch_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      badaddr_q     <= {width{1'b0}};
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      misalign_q    <= misalign_d;
      badaddr_q     <= badaddr_d;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign PC          = pc_q;
  assign misalign    = misalign_q;
  assign badaddr     = badaddr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios with literal expectations
// followed by randomized traffic checked against a behavioural model.
module tb_pc_gen;

  localparam logic [31:0] TRAP = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] PC;
  logic        misalign;
  logic [31:0] badaddr;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of the fetch front end
  bit [31:0] m_pc, m_bad, m_ptgt;
  bit        m_fv, m_mis, m_idle, m_pv, m_pt;

  pc_gen dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .halt            (halt),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap            (trap),
    .fetch_ready     (fetch_ready),
    .fetch_valid     (fetch_valid),
    .PC              (PC),
    .misalign        (misalign),
    .badaddr         (badaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc = 32'h0; m_bad = 32'h0; m_ptgt = 32'h0;
    m_fv = 1'b0; m_mis = 1'b0; m_idle = 1'b1; m_pv = 1'b0; m_pt = 1'b0;
  endtask

  task automatic compare_all();
    chk("pc", PC, m_pc);
    chk("fetch_valid", {31'h0, fetch_valid}, {31'h0, m_fv});
    chk("misalign", {31'h0, misalign}, {31'h0, m_mis});
    chk("badaddr", badaddr, m_bad);
  endtask

  // Advance one clock: predict from the inputs now on the pins, then compare at the falling edge.
  task automatic cycle();
    bit        ev, mis, evtrap, n_fv, n_idle;
    bit [31:0] evtgt, n_pc;
    if (!reset_n) begin
      @(posedge clk);
      m_reset();
    end else begin
      ev     = trap || redirect_valid;
      mis    = redirect_valid && (redirect_target[1:0] != 2'b00);
      evtrap = trap || mis;
      evtgt  = evtrap ? TRAP : redirect_target;
      n_pc   = m_pc;
      n_fv   = m_fv;
      n_idle = 1'b0;
      if (m_fv && !fetch_ready) begin
        if (ev && (!m_pv || !m_pt || evtrap)) begin
          m_pv = 1'b1; m_pt = evtrap; m_ptgt = evtgt;
        end
      end else if (m_fv) begin
        if (m_pv)    n_pc = m_ptgt;
        else if (ev) n_pc = evtgt;
        else         n_pc = m_pc + 32'd4;
        m_pv = 1'b0;
        n_fv = !halt;
      end else begin
        if (ev) n_pc = evtgt;
        n_fv = m_idle ? 1'b1 : !halt;
      end
      @(posedge clk);
      m_pc   = n_pc;
      m_fv   = n_fv;
      m_idle = n_idle;
      m_mis  = mis;
      if (mis) m_bad = redirect_target;
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic redir(input logic [31:0] t);
    redirect_valid = 1'b1; redirect_target = t;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    trap = 1'b0; fetch_ready = 1'b1;
    m_reset();
    #1;
    chk("reset_pc", PC, 32'h0);
    chk("reset_fv", {31'h0, fetch_valid}, 32'h0);
    chk("reset_mis", {31'h0, misalign}, 32'h0);
    chk("reset_bad", badaddr, 32'h0);

    // Reset release and sequential fetch
    @(negedge clk);
    reset_n = 1'b1;
    cycle(); chk("first_req_pc", PC, 32'h0); chk("first_req_fv", {31'h0, fetch_valid}, 32'h1);
    cycle(); cycle(); chk("seq_pc8", PC, 32'h8);
    cycle(); chk("seq_pcC", PC, 32'hC);

    // Redirect without stall
    redir(32'h8);
    redir(32'h40); chk("redir_40", PC, 32'h40);
    cycle();       chk("redir_44", PC, 32'h44);

    // Two redirects during a stall: the newer wins
    redir(32'h8);
    fetch_ready = 1'b0;
    redir(32'h40); redir(32'h80); cycle();
    chk("stall_hold", PC, 32'h8);
    fetch_ready = 1'b1;
    cycle(); chk("stall_redir80", PC, 32'h80);

    // Trap during a stall is not displaced by a later redirect
    redir(32'h8);
    fetch_ready = 1'b0;
    redir(32'h40);
    trap = 1'b1; cycle(); trap = 1'b0;
    redir(32'h80);
    fetch_ready = 1'b1;
    cycle(); chk("stall_trap", PC, 32'h100);

    // Misaligned redirect
    redir(32'h42);
    chk("mis_pc", PC, 32'h100); chk("mis_pulse", {31'h0, misalign}, 32'h1); chk("mis_bad", badaddr, 32'h42);
    cycle();
    chk("mis_clear", {31'h0, misalign}, 32'h0); chk("mis_bad_hold", badaddr, 32'h42);

    // Halt while stalled, redirect while halted, resume
    redir(32'hC);
    fetch_ready = 1'b0; halt = 1'b1;
    cycle(); cycle(); chk("halt_stall_pc", PC, 32'hC); chk("halt_stall_fv", {31'h0, fetch_valid}, 32'h1);
    fetch_ready = 1'b1;
    cycle(); chk("halted_fv", {31'h0, fetch_valid}, 32'h0); chk("halted_pc", PC, 32'h10);
    redir(32'h20); chk("halted_redir_pc", PC, 32'h20); chk("halted_redir_fv", {31'h0, fetch_valid}, 32'h0);
    halt = 1'b0;
    cycle(); chk("resume_pc", PC, 32'h20); chk("resume_fv", {31'h0, fetch_valid}, 32'h1);

    // Address wrap
    redir(32'hFFFF_FFFC);
    cycle(); chk("wrap", PC, 32'h0);

    // Asynchronous reset mid-stall with a pending entry
    redir(32'h8);
    fetch_ready = 1'b0;
    redir(32'h40);
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    chk("async_rst_pc", PC, 32'h0); chk("async_rst_fv", {31'h0, fetch_valid}, 32'h0);
    @(negedge clk);
    cycle();
    reset_n = 1'b1; fetch_ready = 1'b1;
    cycle(); chk("post_rst_pc0", PC, 32'h0);
    cycle(); chk("post_rst_pc4", PC, 32'h4);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(999, 0) < 4) begin
        #2 reset_n = 1'b0;
        #1;
        m_reset();
        compare_all();
        @(negedge clk);
        cycle();
        reset_n = 1'b1;
      end
      fetch_ready    = ($urandom_range(99, 0) < 65);
      if ($urandom_range(99, 0) < 6) halt = ~halt;
      trap           = ($urandom_range(99, 0) < 5);
      redirect_valid = ($urandom_range(99, 0) < 25);
      case ($urandom_range(3, 0))
        0:       redirect_target = $urandom();
        1:       redirect_target = 32'hFFFF_FFF0 | ($urandom_range(3, 0) << 2);
        default: redirect_target = $urandom() & 32'hFFFF_FFFC;
      endcase
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RISC-V fetch front end. It supersedes the bare PC register with four additions: a valid/ready fetch handshake, a halt state, and redirect and trap sources. It also holds a one-entry pending-redirect buffer, so redirects that arrive while a fetch is stalled are not lost. It sits between the control/branch logic and instruction memory, and drives the fetch address every cycle.

## Interface
Parameters:
- width, 32, PC and address width in bits
- RESET_VEC, 0, PC value loaded at reset
- TRAP_VEC, 32'h0000_0100, target taken on trap or misaligned redirect
- INC, 4, sequential increment in bytes

Ports:
- clk  in  1  rising-edge clock, the only clock
- reset_n  in  1  reset, asynchronous and active-low
- halt  in  1  level; request to stop issuing fetches
- redirect_valid  in  1  one-cycle pulse; branch/jump taken
- redirect_target  in  width  new PC, sampled when redirect_valid=1
- trap  in  1  one-cycle pulse; exception/interrupt entry
- fetch_ready  in  1  instruction memory accepts the current PC
- fetch_valid  out  1  PC is a valid fetch request
- PC  out  width  current fetch address
- misalign  out  1  one-cycle pulse; the redirect target was not 4-byte aligned
- badaddr  out  width  offending target; valid while misalign=1 and held until the next misalign

## Operation
- States:
  - IDLE: post-reset; fetch_valid=0.
  - RUN: fetch_valid=1.
  - HALTED: fetch_valid=0.
- State transitions:
  - IDLE→RUN unconditionally after one cycle.
  - RUN→HALTED when halt=1 and no fetch is outstanding.
  - HALTED→RUN when halt=0.
- Outstanding fetch: fetch_valid=1 and fetch_ready=0. While outstanding, PC and fetch_valid hold stable; a request is never withdrawn.
- Handshake: fetch_valid=1 and fetch_ready=1. On a handshake, the next PC is chosen in this order:
  1. the pending entry, if present;
  2. else the current-cycle event;
  3. else PC+INC.
- Event priority within one cycle: trap > redirect > sequential.
- Misaligned redirect: redirect_target[1:0]≠0. It is treated as a trap to TRAP_VEC; misalign pulses and badaddr captures the target.
- Pending buffer: one entry holding {is_trap, target}.
  - Events are written to the buffer only while a fetch is outstanding.
  - A newer redirect overwrites a pending redirect.
  - A trap overwrites anything.
  - A redirect never overwrites a pending trap.
  - The buffer is cleared when its entry is consumed.
- When not outstanding (IDLE, HALTED, or RUN without a stall), an event loads PC directly at the next edge, with no buffering. In HALTED the PC updates but the state stays HALTED.
- Arithmetic: PC+INC is modulo 2^width. 32'hFFFF_FFFC+4 wraps to 0, with no flag.
- Reset, including mid-operation: PC=RESET_VEC, fetch_valid=0, misalign=0, badaddr=0, state=IDLE, pending cleared. Every output takes its reset value asynchronously.

## Timing
- All outputs are registered. Every PC change takes effect at the edge after the cause: handshake, event, or IDLE exit.
- First request: fetch_valid=1 with PC=RESET_VEC on the first edge after reset_n rises.
- Redirect with no stall: PC=target one cycle after the pulse. Redirect during a stall: applied at the edge of the completing handshake.
- misalign asserts in the cycle after the offending redirect is sampled, whether or not it is buffered.
- halt is honoured at the first edge with no fetch outstanding. fetch_valid falls on that edge.
- Sustained throughput: one PC per cycle while fetch_ready=1.

## Structure
- Shared package (rv_pkg):
  - state enum {IDLE, RUN, HALTED};
  - the INSTR_ALIGN_MASK constant, 2'b11;
  - the default TRAP_VEC.
- One sub-module: pc_redirect_buf, the pending entry with its overwrite-priority logic. The PC register, next-PC mux and FSM stay in pc_gen.

## Test plan
- Reset release, fetch_ready=1 → fetch_valid rises one cycle after reset_n; PC sequence is 0,4,8,C.
- PC=8, fetch_ready=1, redirect to 32'h40 → next PC=40, then 44.
- PC=8, fetch_ready=0 for 3 cycles, with redirect 32'h40 then redirect 32'h80 during the stall → PC holds 8; after the handshake PC=80. Repeat with trap after the redirect → PC=100.
- Redirect to 32'h42 → PC=100, misalign pulses for 1 cycle, badaddr=42.
- halt=1 while stalled at PC=C → PC holds until fetch_ready=1; then fetch_valid=0 and state HALTED. Redirect to 20 while halted → PC=20, fetch_valid stays 0. halt=0 → fetch_valid=1 with PC=20.
- PC=FFFF_FFFC with handshake → PC=0. Assert reset_n=0 mid-stall with a pending entry → PC=0 and fetch_valid=0 immediately; the pending entry is not applied after release.
